// File: rtl/square_scheduler.sv
// rtl/square_scheduler.sv - spawn/update/respawn sequencer for a bank of square units
// Optional score counter enabled by defining SQ_SCORE_COUNT_EN.
module square_scheduler #(
   parameter int NUM_SQ  = 4,
   parameter int SPEED   = 2,
   parameter int STAGGER = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  vsync,
   input  logic                  game_run,
   input  logic [7:0]            random,
   input  logic [6*NUM_SQ-1:0]   depth_in,
   output logic [NUM_SQ-1:0]     sq_enable,
   output logic [NUM_SQ-1:0]     sq_reset,
   output logic [12:0]           rvalue,
   output logic                  busy,
   output logic                  overrun,
   output logic [9:0]            score
);

   localparam int KW = (NUM_SQ > 1) ? $clog2(NUM_SQ) : 1;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] SPAWN   = 3'd1;
   localparam logic [2:0] WAIT    = 3'd2;
   localparam logic [2:0] UPDATE  = 3'd3;
   localparam logic [2:0] CHECK   = 3'd4;
   localparam logic [2:0] RESPAWN = 3'd5;

   logic [2:0]        state;
   logic [KW-1:0]     k;
   logic [3:0]        fcnt;
   logic [NUM_SQ-1:0] mask;
   logic [NUM_SQ-1:0] zero_vec;
   logic [NUM_SQ-1:0] k_onehot;
   logic [5:0]        spawn_depth;
   logic              vsync_q;
   logic              tick;
   logic              last_k;
   logic              unused_random;

   assign tick          = vsync & ~vsync_q;
   assign last_k        = (k == KW'(NUM_SQ - 1));
   assign k_onehot      = NUM_SQ'(1) << k;
   assign busy          = (state != IDLE) && (state != WAIT);
   assign unused_random = ^random[7:4];

   // Initial slots are spread back from the far plane so they arrive one after another.
   always_comb begin
      spawn_depth = 6'(63 - int'(k) * STAGGER);
   end

   always_comb begin
      zero_vec = '0;
      for (int i = 0; i < NUM_SQ; i++) begin
         zero_vec[i] = (depth_in[6*i +: 6] == 6'd0);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         k         <= '0;
         fcnt      <= '0;
         mask      <= '0;
         vsync_q   <= 1'b0;
         sq_enable <= '0;
         sq_reset  <= '0;
         rvalue    <= '0;
         overrun   <= 1'b0;
      end else begin
         vsync_q   <= vsync;
         sq_enable <= '0;
         sq_reset  <= '0;
         if (tick && (state != WAIT)) begin
            overrun <= 1'b1;
         end
         if (!game_run) begin
            state <= IDLE;
            k     <= '0;
            mask  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state   <= SPAWN;
                  k       <= '0;
                  overrun <= 1'b0;
               end
               SPAWN: begin
                  sq_reset <= k_onehot;
                  rvalue   <= {spawn_depth, 7'b0};
                  if (last_k) begin
                     state <= WAIT;
                     k     <= '0;
                     fcnt  <= '0;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
               WAIT: begin
                  if (tick) begin
                     if (fcnt == 4'(SPEED - 1)) begin
                        fcnt  <= '0;
                        k     <= '0;
                        state <= UPDATE;
                     end else begin
                        fcnt <= fcnt + 4'd1;
                     end
                  end
               end
               UPDATE: begin
                  sq_enable <= k_onehot;
                  if (last_k) begin
                     state <= CHECK;
                     k     <= '0;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
               CHECK: begin
                  mask  <= zero_vec;
                  k     <= '0;
                  state <= (|zero_vec) ? RESPAWN : WAIT;
               end
               RESPAWN: begin
                  // Scan every slot so the sweep length is fixed regardless of how many respawn.
                  if (mask[k]) begin
                     sq_reset <= k_onehot;
                     rvalue   <= {2'b11, random[3:0], 7'b0};
                     mask[k]  <= 1'b0;
                  end
                  if (last_k) begin
                     state <= WAIT;
                     k     <= '0;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  k     <= '0;
               end
            endcase
         end
      end
   end

`ifdef SQ_SCORE_COUNT_EN
   logic [9:0] score_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         score_q <= '0;
      end else if (game_run && (state == RESPAWN) && mask[k] && (score_q != 10'd1023)) begin
         score_q <= score_q + 10'd1;
      end
   end

   assign score = score_q;
`else
   assign score = '0;
`endif

endmodule

// File: tb/tb_square_scheduler.sv
// tb/tb_square_scheduler.sv - randomized self-checking bench for square_scheduler
// Score expectations follow SQ_SCORE_COUNT_EN when defined.
module tb_square_scheduler;

   localparam int NUM_SQ  = 4;
   localparam int SPEED   = 2;
   localparam int STAGGER = 16;
   localparam int WIN     = 3 * NUM_SQ + 8;

   logic                clock = 1'b0;
   logic                reset = 1'b0;
   logic                vsync = 1'b0;
   logic                game_run = 1'b0;
   logic [7:0]          random = 8'h00;
   logic [6*NUM_SQ-1:0] depth_in = '1;
   logic [NUM_SQ-1:0]   sq_enable;
   logic [NUM_SQ-1:0]   sq_reset;
   logic [12:0]         rvalue;
   logic                busy;
   logic                overrun;
   logic [9:0]          score;

   square_scheduler #(.NUM_SQ(NUM_SQ), .SPEED(SPEED), .STAGGER(STAGGER)) dut (
      .clock    (clock),
      .reset    (reset),
      .vsync    (vsync),
      .game_run (game_run),
      .random   (random),
      .depth_in (depth_in),
      .sq_enable(sq_enable),
      .sq_reset (sq_reset),
      .rvalue   (rvalue),
      .busy     (busy),
      .overrun  (overrun),
      .score    (score)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // model state: frames since last sweep, sticky overrun, squares passed
   int fcnt_m  = 0;
   int ovr_m   = 0;
   int score_m = 0;

   int          en_slot[$];
   int          en_cyc[$];
   int          rs_slot[$];
   int          rs_cyc[$];
   logic [12:0] rs_val[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int slot_of(input logic [NUM_SQ-1:0] v);
      for (int i = 0; i < NUM_SQ; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic check_score();
`ifdef SQ_SCORE_COUNT_EN
      check("score", 32'(score), 32'(score_m));
`else
      check("score", 32'(score), 32'd0);
`endif
   endtask

   task automatic sample(input int cyc);
      check("strobe_excl", 32'((sq_enable != 0) && (sq_reset != 0)), 32'd0);
      check("en_onehot0", 32'($onehot0(sq_enable)), 32'd1);
      check("rs_onehot0", 32'($onehot0(sq_reset)), 32'd1);
      if (sq_enable != 0) begin
         en_slot.push_back(slot_of(sq_enable));
         en_cyc.push_back(cyc);
      end
      if (sq_reset != 0) begin
         rs_slot.push_back(slot_of(sq_reset));
         rs_cyc.push_back(cyc);
         rs_val.push_back(rvalue);
      end
   endtask

   task automatic wait_strobe(input bit on_reset, input logic [NUM_SQ-1:0] val, input string tag);
      for (int n = 0; n < 40; n++) begin
         @(negedge clock);
         if (on_reset ? (sq_reset == val) : (sq_enable == val)) return;
      end
      check(tag, 32'd0, 32'd1);
   endtask

   task automatic do_spawn();
      int spawn_exp[4] = '{63, 47, 31, 15};
      game_run = 1'b1;
      wait_strobe(1'b1, NUM_SQ'(1), "spawn_start");
      for (int i = 0; i < NUM_SQ; i++) begin
         check($sformatf("spawn_rs%0d", i), 32'(sq_reset), 32'(1 << i));
         check($sformatf("spawn_rv%0d", i), 32'(rvalue), 32'(spawn_exp[i] << 7));
         check($sformatf("spawn_en%0d", i), 32'(sq_enable), 32'd0);
         @(negedge clock);
      end
      check("spawn_end_rs", 32'(sq_reset), 32'd0);
      check("spawn_end_busy", 32'(busy), 32'd0);
      fcnt_m = 0;
      ovr_m  = 0;
      check("spawn_ovr", 32'(overrun), 32'd0);
   endtask

   task automatic run_frame(input logic [6*NUM_SQ-1:0] dep, input logic [7:0] rnd);
      int   zeros[$];
      bit   swept;
      logic [12:0] exp_rv;
      depth_in = dep;
      random   = rnd;
      en_slot.delete(); en_cyc.delete(); rs_slot.delete(); rs_cyc.delete(); rs_val.delete();
      fcnt_m++;
      swept = (fcnt_m == SPEED);
      if (swept) fcnt_m = 0;
      for (int c = 0; c < WIN; c++) begin
         vsync = (c < 2);
         @(negedge clock);
         sample(c);
      end
      for (int i = 0; i < NUM_SQ; i++) begin
         if (dep[6*i +: 6] == 6'd0) zeros.push_back(i);
      end
      exp_rv = {2'b11, rnd[3:0], 7'b0};
      if (swept) begin
         check("sweep_en_cnt", 32'(en_slot.size()), 32'(NUM_SQ));
         for (int i = 0; i < en_slot.size() && i < NUM_SQ; i++) begin
            check("sweep_en_slot", 32'(en_slot[i]), 32'(i));
            check("sweep_en_cyc", 32'(en_cyc[i]), 32'(en_cyc[0] + i));
         end
         check("resp_cnt", 32'(rs_slot.size()), 32'(zeros.size()));
         for (int i = 0; i < rs_slot.size() && i < zeros.size(); i++) begin
            check("resp_slot", 32'(rs_slot[i]), 32'(zeros[i]));
            check("resp_rv", 32'(rs_val[i]), 32'(exp_rv));
            if (en_cyc.size() > 0) begin
               check("resp_after_en", 32'(rs_cyc[i] > en_cyc[en_cyc.size()-1]), 32'd1);
            end
         end
         score_m = score_m + zeros.size();
         if (score_m > 1023) score_m = 1023;
      end else begin
         check("idle_en_cnt", 32'(en_slot.size()), 32'd0);
         check("idle_rs_cnt", 32'(rs_slot.size()), 32'd0);
      end
      check("frame_busy", 32'(busy), 32'd0);
      check("frame_ovr", 32'(overrun), 32'(ovr_m));
      check_score();
   endtask

   task automatic align_to_sweep();
      while (fcnt_m != SPEED - 1) run_frame('1, 8'h00);
   endtask

   function automatic logic [6*NUM_SQ-1:0] rand_depths();
      logic [6*NUM_SQ-1:0] d;
      for (int i = 0; i < NUM_SQ; i++) begin
         d[6*i +: 6] = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      end
      return d;
   endfunction

   initial begin
      logic [6*NUM_SQ-1:0] dep;

      repeat (3) @(negedge clock);
      check("rst_en", 32'(sq_enable), 32'd0);
      check("rst_rs", 32'(sq_reset), 32'd0);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("idle_en", 32'(sq_enable), 32'd0);
      check("idle_rs", 32'(sq_reset), 32'd0);
      check("idle_rv", 32'(rvalue), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ovr", 32'(overrun), 32'd0);
      check("idle_score", 32'(score), 32'd0);

      do_spawn();

      for (int f = 0; f < 12; f++) run_frame(rand_depths(), 8'($urandom));

      // single far slot reaching the viewer
      align_to_sweep();
      dep = '1;
      dep[12 +: 6] = 6'd0;
      run_frame(dep, 8'h05);

      // frame tick landing in the middle of an update sweep
      align_to_sweep();
      depth_in = '1;
      vsync = 1'b1;
      @(negedge clock);
      vsync = 1'b0;
      wait_strobe(1'b0, 4'b0001, "ovr_sweep_start");
      vsync = 1'b1;
      @(negedge clock);
      check("ovr_en1", 32'(sq_enable), 32'b0010);
      vsync = 1'b0;
      @(negedge clock);
      check("ovr_en2", 32'(sq_enable), 32'b0100);
      @(negedge clock);
      check("ovr_en3", 32'(sq_enable), 32'b1000);
      fcnt_m = 0;
      ovr_m  = 1;
      repeat (4) @(negedge clock);
      check("ovr_set", 32'(overrun), 32'd1);
      run_frame('1, 8'h3c);
      run_frame('1, 8'h3c);

      // game_run dropped mid-sweep
      align_to_sweep();
      depth_in = '0;
      vsync = 1'b1;
      @(negedge clock);
      vsync = 1'b0;
      wait_strobe(1'b0, 4'b0010, "drop_wait");
      game_run = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("drop_en", 32'(sq_enable), 32'd0);
         check("drop_rs", 32'(sq_reset), 32'd0);
         check("drop_busy", 32'(busy), 32'd0);
      end
      check("drop_ovr_held", 32'(overrun), 32'd1);
      check_score();

      do_spawn();
      run_frame(rand_depths(), 8'($urandom));
      run_frame(rand_depths(), 8'($urandom));

      // async reset during respawn
      align_to_sweep();
      depth_in = '0;
      vsync = 1'b1;
      @(negedge clock);
      vsync = 1'b0;
      wait_strobe(1'b1, 4'b0010, "rst_resp_wait");
      check("rst_pre_rs", 32'(sq_reset), 32'b0010);
      #1 reset = 1'b0;
      #1;
      check("rst_async_rs", 32'(sq_reset), 32'd0);
      check("rst_async_en", 32'(sq_enable), 32'd0);
      check("rst_async_rv", 32'(rvalue), 32'd0);
      check("rst_async_busy", 32'(busy), 32'd0);
      check("rst_async_score", 32'(score), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
